// File: rtl/mult_seq_nxn.sv
// ============================================================================
//  Module   : mult_seq_nxn (with its mult4x4 partial-product cell)
//  Purpose  : Sequential NxN multiplier: one 4x4 nibble product per clock,
//             shifted and accumulated into a 2*WIDTH result.
//  Options  : define MULT_SIGNED_EN for two's-complement operands/result.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult4x4 (
    input  logic [3:0] dataa,
    input  logic [3:0] datab,
    output logic [7:0] product
);

    logic [7:0] w_row [4];

    for (genvar k = 0; k < 4; k++) begin : g_row
        assign w_row[k] = datab[k] ? (8'(dataa) << k) : 8'd0;
    end

    assign product = w_row[0] + w_row[1] + w_row[2] + w_row[3];

endmodule

module mult_seq_nxn #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int DIGITS = WIDTH / 4;
    localparam int PW     = 2 * WIDTH;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [IW-1:0] c_last_idx = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("mult_seq_nxn: WIDTH must be a multiple of 4 and >= 4");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_i;
    logic [IW-1:0]    r_j;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_product;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [7:0]       w_pp;
    logic [IW:0]      w_ij;
    logic [IW+2:0]    w_shamt;
    logic [PW-1:0]    w_term;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_final;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_i == c_last_idx) && (r_j == c_last_idx);

    // Select the current nibble pair by shifting it down to bit 0.
    assign w_a_shift = r_a >> {r_i, 2'b00};
    assign w_b_shift = r_b >> {r_j, 2'b00};

    mult4x4 u_mult4x4 (
        .dataa   (w_a_shift[3:0]),
        .datab   (w_b_shift[3:0]),
        .product (w_pp)
    );

    assign w_ij    = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt = {w_ij, 2'b00};
    assign w_term  = PW'(w_pp) << w_shamt;
    assign w_sum   = r_acc + w_term;

`ifdef MULT_SIGNED_EN
    logic r_sign;

    // Negating the most-negative value yields 2^(W-1), which is exactly the
    // required unsigned magnitude, so no special case is needed.
    assign w_mag_a = dataa[WIDTH-1] ? (~dataa + 1'b1) : dataa;
    assign w_mag_b = datab[WIDTH-1] ? (~datab + 1'b1) : datab;
    assign w_final = r_sign ? (~w_sum + 1'b1) : w_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_sign <= dataa[WIDTH-1] ^ datab[WIDTH-1];
        end
    end
`else
    assign w_mag_a = dataa;
    assign w_mag_b = datab;
    assign w_final = w_sum;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_CALC:  busy = 1'b1;
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latches, nibble indices, accumulator, result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= w_mag_a;
            r_b   <= w_mag_b;
            r_i   <= '0;
            r_j   <= '0;
            r_acc <= '0;
        end else if (r_state == S_CALC) begin
            r_acc <= w_sum;
            if (w_last) begin
                // Result only ever sees the completed sum.
                r_product <= w_final;
                r_i       <= '0;
                r_j       <= '0;
            end else if (r_j == c_last_idx) begin
                r_j <= '0;
                r_i <= r_i + 1'b1;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end
    end

    assign product = r_product;

endmodule

`default_nettype wire
